// File: rtl/pq_pkg.sv
// Shared widths and the packed key/value type for the register-array priority queue.
// The key sits in the upper KW bits and the value in the lower VW bits.
package pq_pkg;
    localparam int KW = 8;
    localparam int VW = 8;
    typedef logic [KW+VW-1:0] kv_t;
endpackage

// File: rtl/ra_pq_s.sv
// Register-array priority queue: a sorted shift-register array with the minimum key at slot 0.
// Enqueue, dequeue and replace each finish in a single clock.
module ra_pq_s
    import pq_pkg::*;
#(
    parameter int PQ_CAPACITY = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enq,
    input  logic             deq,
    input  logic [KW+VW-1:0] kvi,
    output logic [KW+VW-1:0] kvo,
    output logic             full,
    output logic             empty,
    output logic             busy
);
    localparam int N  = PQ_CAPACITY;
    localparam int CW = $clog2(PQ_CAPACITY + 1);

    kv_t            ent      [N];
    logic [N-1:0]   vld;
    logic [CW-1:0]  count;

    kv_t            base_ent [N];
    logic [N-1:0]   base_vld;
    kv_t            nxt_ent  [N];
    logic [N-1:0]   nxt_vld;
    logic [N-1:0]   gt;
    logic [CW-1:0]  nxt_count;
    logic           do_deq;
    logic           do_enq;

    assign empty  = (count == '0);
    assign full   = (count == CW'(N));
    assign busy   = 1'b0;
    assign do_deq = deq && !empty;
    // A dequeue in the same cycle frees a slot, so replace is allowed on a full queue.
    assign do_enq = enq && (!full || do_deq);

    assign kvo = vld[0] ? ent[0] : {{KW{1'b1}}, {VW{1'b0}}};

    // Stage 1: remove the head by shifting everything down one slot.
    always_comb begin
        base_ent = ent;
        base_vld = vld;
        if (do_deq) begin
            for (int i = 0; i < N - 1; i++) begin
                base_ent[i] = ent[i + 1];
            end
            base_vld = {1'b0, vld[N-1:1]};
        end
    end

    // Stage 2: gt is monotonic over the sorted contiguous array, so its first set bit is the insert slot.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            gt[i] = !base_vld[i] || (base_ent[i][KW+VW-1:VW] > kvi[KW+VW-1:VW]);
        end
    end

    always_comb begin
        nxt_ent = base_ent;
        nxt_vld = base_vld;
        if (do_enq) begin
            if (gt[0]) begin
                nxt_ent[0] = kvi;
                nxt_vld[0] = 1'b1;
            end
            for (int i = 1; i < N; i++) begin
                if (gt[i]) begin
                    if (!gt[i - 1]) begin
                        nxt_ent[i] = kvi;
                        nxt_vld[i] = 1'b1;
                    end else begin
                        nxt_ent[i] = base_ent[i - 1];
                        nxt_vld[i] = base_vld[i - 1];
                    end
                end
            end
        end
    end

    always_comb begin
        nxt_count = count;
        if (do_enq && !do_deq) begin
            nxt_count = count + CW'(1);
        end else if (do_deq && !do_enq) begin
            nxt_count = count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld   <= '0;
            count <= '0;
        end else begin
            vld   <= nxt_vld;
            count <= nxt_count;
            ent   <= nxt_ent;
        end
    end

endmodule

// File: tb/tb_ra_pq_s.sv
// Scoreboard bench for ra_pq_s: the driver pushes expected post-edge state from a sorted-queue model,
// and an independent monitor pops and compares just after each rising edge.
module tb_ra_pq_s;
    localparam int W   = 16;
    localparam int CAP = 16;
    localparam logic [W-1:0] SENTINEL = 16'hFF00;

    typedef struct {
        logic [W-1:0] kv;
        logic         full;
        logic         empty;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         enq = 1'b0;
    logic         deq = 1'b0;
    logic [W-1:0] kvi = '0;
    logic [W-1:0] kvo;
    logic         full;
    logic         empty;
    logic         busy;

    logic [W-1:0] model [$];
    exp_t         exp_q [$];
    int           n_cmp = 0;
    int           n_bad = 0;

    ra_pq_s #(.PQ_CAPACITY(CAP)) dut (
        .clk   (clk),
        .rst   (rst),
        .enq   (enq),
        .deq   (deq),
        .kvi   (kvi),
        .kvo   (kvo),
        .full  (full),
        .empty (empty),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    // Reference: a plain sorted list; insertion goes after every entry with key <= new key.
    task automatic modelInsert(input logic [W-1:0] kv);
        int p;
        p = model.size();
        for (int i = 0; i < model.size(); i++) begin
            if (model[i][15:8] > kv[15:8]) begin
                p = i;
                break;
            end
        end
        model.insert(p, kv);
    endtask

    task automatic applyStimulus(input logic r, input logic e, input logic d, input logic [W-1:0] kv);
        exp_t x;
        bit   dd;
        bit   de;
        @(negedge clk);
        rst = r;
        enq = e;
        deq = d;
        kvi = kv;
        if (r) begin
            model.delete();
        end else begin
            dd = d && (model.size() > 0);
            de = e && ((model.size() < CAP) || dd);
            if (dd) void'(model.pop_front());
            if (de) modelInsert(kv);
        end
        x.kv    = (model.size() > 0) ? model[0] : SENTINEL;
        x.full  = (model.size() == CAP);
        x.empty = (model.size() == 0);
        exp_q.push_back(x);
    endtask

    task automatic checkOutput(input exp_t x);
        n_cmp++;
        if (kvo !== x.kv) begin
            n_bad++;
            $display("[TB] FAIL kvo: got %h expected %h at %0t", kvo, x.kv, $time);
        end
        n_cmp++;
        if ({full, empty, busy} !== {x.full, x.empty, 1'b0}) begin
            n_bad++;
            $display("[TB] FAIL flags(full,empty,busy): got %b%b%b expected %b%b0 at %0t",
                     full, empty, busy, x.full, x.empty, $time);
        end
    endtask

    // Monitor: one expectation per clock, sampled 1 time unit after the rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) checkOutput(exp_q.pop_front());
        end
    end

    task automatic idle();
        applyStimulus(1'b0, 1'b0, 1'b0, $urandom);
    endtask

    initial begin
        $display("[TB] start");
        applyStimulus(1'b1, 1'b0, 1'b0, '0);
        applyStimulus(1'b1, 1'b0, 1'b0, '0);
        idle();

        // Sort order
        applyStimulus(1'b0, 1'b1, 1'b0, {8'd5, 8'd50});
        applyStimulus(1'b0, 1'b1, 1'b0, {8'd3, 8'd30});
        applyStimulus(1'b0, 1'b1, 1'b0, {8'd9, 8'd90});
        applyStimulus(1'b0, 1'b1, 1'b0, {8'd1, 8'd10});
        repeat (4) applyStimulus(1'b0, 1'b0, 1'b1, $urandom);
        idle();

        // Equal keys leave in arrival order
        for (int v = 1; v <= 3; v++) applyStimulus(1'b0, 1'b1, 1'b0, {8'd7, 8'(v)});
        repeat (3) applyStimulus(1'b0, 1'b0, 1'b1, $urandom);

        // Fill, overflow attempt, drain, underflow attempt
        for (int k = 16; k >= 1; k--) applyStimulus(1'b0, 1'b1, 1'b0, {8'(k), 8'($urandom)});
        applyStimulus(1'b0, 1'b1, 1'b0, {8'd0, 8'hAA});
        repeat (16) applyStimulus(1'b0, 1'b0, 1'b1, $urandom);
        applyStimulus(1'b0, 1'b0, 1'b1, $urandom);
        idle();

        // Replace on a partial queue, then on a full queue
        applyStimulus(1'b0, 1'b1, 1'b0, {8'd2, 8'd20});
        applyStimulus(1'b0, 1'b1, 1'b0, {8'd6, 8'd60});
        applyStimulus(1'b0, 1'b1, 1'b0, {8'd8, 8'd80});
        applyStimulus(1'b0, 1'b1, 1'b1, {8'd5, 8'd55});
        repeat (3) applyStimulus(1'b0, 1'b0, 1'b1, $urandom);
        for (int k = 1; k <= 16; k++) applyStimulus(1'b0, 1'b1, 1'b0, {8'(k * 3), 8'(k)});
        applyStimulus(1'b0, 1'b1, 1'b1, {8'd20, 8'hBB});
        applyStimulus(1'b0, 1'b1, 1'b1, {8'd0, 8'hCC});
        applyStimulus(1'b0, 1'b1, 1'b1, {8'd255, 8'hDD});

        // Reset with an enqueue pending
        applyStimulus(1'b1, 1'b0, 1'b0, '0);
        for (int k = 0; k < 3; k++) applyStimulus(1'b0, 1'b1, 1'b0, $urandom);
        applyStimulus(1'b1, 1'b1, 1'b0, {8'd1, 8'd1});
        idle();

        // Random mix with many duplicate keys and occasional resets
        for (int n = 0; n < 3000; n++) begin
            logic [W-1:0] kv;
            int           sel;
            kv  = ($urandom_range(0, 3) == 0) ? W'($urandom)
                                              : {8'($urandom_range(0, 12)), 8'($urandom)};
            sel = $urandom_range(0, 99);
            if (sel == 0)       applyStimulus(1'b1, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, kv);
            else if (sel < 45)  applyStimulus(1'b0, 1'b1, 1'b0, kv);
            else if (sel < 80)  applyStimulus(1'b0, 1'b0, 1'b1, kv);
            else if (sel < 95)  applyStimulus(1'b0, 1'b1, 1'b1, kv);
            else                applyStimulus(1'b0, 1'b0, 1'b0, kv);
        end

        @(negedge clk);
        enq = 1'b0;
        deq = 1'b0;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("[TB] FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
